// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x32 integer register file.
// Holds the data/address widths, register count, FSM state encoding and the
// hardwired-zero register index.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_32x32_mux.sv
// 32-to-1 word mux: selects one DATA_W word out of NUM_REGS inputs.
// Ports:
//   words - all NUM_REGS candidate words, index i on words[i]
//   sel   - 5-bit word select
//   word  - selected word (combinational)
module regfile_32x32_mux
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0][DATA_W-1:0] words,
  input  logic [ADDR_W-1:0]               sel,
  output logic [DATA_W-1:0]               word
);

  assign word = words[sel];

endmodule : regfile_32x32_mux

// File: rtl/regfile_32x32.sv
// 32-entry x 32-bit register file with two combinational read ports, one
// synchronous write port, hardwired-zero %r0 and a one-register-per-cycle
// sequenced clear.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
// forwarding to the read ports (IDLE only, never for index 0).
// Ports:
//   clk, reset           - clock; asynchronous active-high reset
//   we, wr_addr, wr_data - write port (dropped during a clear sweep)
//   rd_addr_a/rd_data_a  - read port A (combinational)
//   rd_addr_b/rd_data_b  - read port B (combinational)
//   clr_req              - pulse that starts a 32-cycle clear sweep
//   busy                 - high while the clear sweep runs
module regfile_32x32
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [31:0]       rd_data_a,
  output logic [31:0]       rd_data_b,
  input  logic              clr_req,
  output logic              busy
);

  state_t                          state, state_nxt;
  logic [ADDR_W-1:0]               cnt, cnt_nxt;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            wr_en;
  logic                            clr_en;
  logic [DATA_W-1:0]               mux_a, mux_b;

  // Clear-sweep FSM state and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: a clr_req in CLEAR is ignored, so the sweep never restarts
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(NUM_REGS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy   = (state == CLEAR);
  assign clr_en = (state == CLEAR);
  // A clr_req arriving with a write wins; %r0 is never written
  assign wr_en  = (state == IDLE) && we && !clr_req && (wr_addr != ZERO_REG);

  // Register array; entry 0 is only ever loaded with zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (clr_en) begin
      regs[cnt] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_32x32_mux u_mux_a (
    .words (regs),
    .sel   (rd_addr_a),
    .word  (mux_a)
  );

  regfile_32x32_mux u_mux_b (
    .words (regs),
    .sel   (rd_addr_b),
    .word  (mux_b)
  );

`ifdef REGFILE_BYPASS_EN
  // Forwarding is keyed on we alone, independent of a concurrent clr_req
  logic fwd_ok;
  assign fwd_ok    = we && (state == IDLE) && (wr_addr != ZERO_REG);
  assign rd_data_a = (fwd_ok && (wr_addr == rd_addr_a)) ? wr_data : mux_a;
  assign rd_data_b = (fwd_ok && (wr_addr == rd_addr_b)) ? wr_data : mux_b;
`else
  assign rd_data_a = mux_a;
  assign rd_data_b = mux_b;
`endif

endmodule : regfile_32x32

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32: directed test-plan steps followed by
// a randomized phase, all compared against an array-based reference model.
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        clr_req = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus sweep position (-1 when idle)
  logic [31:0] mdl [32];
  int          sweep_pos = -1;

  regfile_32x32 dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && sweep_pos < 0 && wr_addr != 5'd0 && a == wr_addr) return wr_data;
`endif
    return mdl[a];
  endfunction

  // One rising edge; the model applies the same inputs the DUT sampled
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      sweep_pos = -1;
    end else if (sweep_pos >= 0) begin
      mdl[sweep_pos] = 32'h0;
      sweep_pos++;
      if (sweep_pos == 32) sweep_pos = -1;
    end else if (clr_req) begin
      sweep_pos = 0;
    end else if (we && wr_addr != 5'd0) begin
      mdl[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rd_addr_a = 5'(k);
      rd_addr_b = 5'(31 - k);
      #1;
      check(tag, rd_data_a, 32'h0);
      check(tag, rd_data_b, 32'h0);
    end
  endtask

  int busy_cycles;

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // Reset state
    #1 reset = 1'b1;
    tick();
    tick();
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd31;
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rd_a", rd_data_a, 32'h0);
    check("reset_rd_b", rd_data_b, 32'h0);
    reset = 1'b0;

    // Write reg[k] = 3k, then read A=k, B=31-k
    for (int k = 1; k < 32; k++) begin
      we = 1'b1; wr_addr = 5'(k); wr_data = 32'(3 * k);
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rd_addr_a = 5'(k);
      rd_addr_b = 5'(31 - k);
      #1;
      check("fill3k_a", rd_data_a, 32'(3 * k));
      check("fill3k_b", rd_data_b, 32'(3 * (31 - k)));
    end

    // Write to %r0 is a no-op
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    tick();
    we = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #1;
    check("r0_write_a", rd_data_a, 32'h0);
    check("r0_write_b", rd_data_b, 32'h0);

    // Same-cycle write/read of reg5
    rd_addr_a = 5'd5;
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr5_same_cycle", rd_data_a, 32'h12345678);
`else
    check("wr5_same_cycle", rd_data_a, 32'd15);
`endif
    check("wr5_same_cycle_model", rd_data_a, exp_rd(5'd5));
    tick();
    we = 1'b0;
    #1;
    check("wr5_next_cycle", rd_data_a, 32'h12345678);

    // Fill with all ones, then sweep
    for (int k = 1; k < 32; k++) begin
      we = 1'b1; wr_addr = 5'(k); wr_data = 32'hFFFFFFFF;
      tick();
    end
    we = 1'b0;
    clr_req = 1'b1;
    #1;
    check("busy_before_clr_edge", 32'(busy), 32'h0);
    tick();
    clr_req = 1'b0;
    check("busy_after_clr_edge", 32'(busy), 32'h1);
    busy_cycles = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      busy_cycles++;
      we = (c == 10); wr_addr = 5'd7; wr_data = 32'h00001234;
      rd_addr_a = 5'd20;
      #1;
      if (c == 10) check("sweep_rd20_c10", rd_data_a, 32'hFFFFFFFF);
      if (c == 25) check("sweep_rd20_c25", rd_data_a, 32'h0);
      tick();
    end
    we = 1'b0;
    check("sweep_busy_cycles", 32'(busy_cycles), 32'd32);
    check_all_zero("after_sweep_zero");

    // clr_req together with a write; second clr_req mid-sweep ignored
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      busy_cycles++;
      clr_req = (c == 5);
      tick();
    end
    clr_req = 1'b0;
    check("reclr_busy_cycles", 32'(busy_cycles), 32'd32);
    rd_addr_a = 5'd9;
    #1;
    check("clr_beats_write_r9", rd_data_a, 32'h0);

    // Reset in the middle of a sweep
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    tick();
    we = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd20;
    #1;
    check("r3_written", rd_data_a, 32'h55);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    #1;
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_rd_a", rd_data_a, 32'h0);
    check("midreset_rd_b", rd_data_b, 32'h0);
    tick();
    #2 reset = 1'b0;
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    tick();
    we = 1'b0;
    #1;
    check("post_reset_write", rd_data_a, 32'h77);
    check("post_reset_busy", 32'(busy), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom_range(0, 1) == 1);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      clr_req   = ($urandom_range(0, 59) == 0);
      #1;
      check("rand_rd_a", rd_data_a, exp_rd(rd_addr_a));
      check("rand_rd_b", rd_data_b, exp_rd(rd_addr_b));
      check("rand_busy", 32'(busy), (sweep_pos >= 0) ? 32'h1 : 32'h0);
      tick();
    end
    we = 1'b0; clr_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_32x32
